bias_loader: RTL and testbench

BIAS_LOADER -- requirements
Module: bias_loader

---
 rtl/bias_loader_pkg.sv | 20 ++
 rtl/bias_loader.sv | 96 +++++++++
 tb/tb_bias_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bias_loader_pkg.sv
// Shared defaults, state encoding and sizing helper for the bias loader.
package bias_loader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N_ELEM     = 4;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_FULL = 1'b1;

  typedef enum logic {
    FILL = ST_FILL,
    FULL = ST_FULL
  } state_e;

  // Element index width; a single-element vector still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_loader.sv
// Double-buffered bias vector loader: streams words into a shadow bank and
// copies it to the active bank when the array controller requests a swap.
module bias_loader
  import bias_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_ELEM     = DEF_N_ELEM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic [N_ELEM*DATA_WIDTH-1:0] bias_out,
  output logic                         bias_valid,
  output logic                         err_len
);

  localparam int IDX_W = idx_width(N_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [N_ELEM-1:0][DATA_WIDTH-1:0]  shadow_q, active_q;
  logic                               wr_en, err, swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Length errors can only arise in FILL and swaps only in FULL, so
  // swap_ack and err_len are mutually exclusive by construction.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_en    = 1'b0;
    err      = 1'b0;
    swap     = 1'b0;
    in_ready = (state_q == FILL);
    case (state_q)
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) state_d = FULL;
            else         err     = 1'b1;
          end else if (in_last) begin
            idx_d = '0;
            err   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (swap_req) begin
          swap    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      active_q   <= '0;
      bias_valid <= 1'b0;
      swap_ack   <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      if (err)        shadow_q        <= '0;
      else if (wr_en) shadow_q[idx_q] <= in_data;
      if (swap) begin
        active_q   <= shadow_q;
        bias_valid <= 1'b1;
      end
      swap_ack <= swap;
      err_len  <= err;
    end
  end

  assign bias_out = active_q;

endmodule

// File: tb/tb_bias_loader.sv
// Scoreboard bench for bias_loader: committed vectors are queued at load time
// and compared against bias_out whenever swap_ack pulses.
module tb_bias_loader;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int W  = DW * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          swap_req, swap_ack, bias_valid, err_len;
  logic [W-1:0]  bias_out;

  int n_chk = 0, n_fail = 0;
  int ack_cnt = 0, err_cnt = 0;
  int send_cycles, load_cycles;
  int a0, e0;
  bit mon_on = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_bias = '0;
  logic [W-1:0] mon_e;
  logic [W-1:0] hold_b;

  bias_loader #(.DATA_WIDTH(DW), .N_ELEM(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .bias_out  (bias_out),
    .bias_valid(bias_valid),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (swap_ack) begin
        ack_cnt++;
        if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("bias_out", bias_out, mon_e);
        end
        chk("ack_bias_valid", bias_valid, 1);
      end else begin
        chk("bias_stable", bias_out, prev_bias);
      end
      if (err_len) err_cnt++;
      if (swap_ack || err_len) chk("ack_err_excl", swap_ack & err_len, 0);
    end
    prev_bias = bias_out;
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
    send_cycles = n;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load4(input logic [DW-1:0] a, b, c, d);
    load_cycles = 0;
    send(a, 1'b0); load_cycles += send_cycles;
    send(b, 1'b0); load_cycles += send_cycles;
    send(c, 1'b0); load_cycles += send_cycles;
    exp_q.push_back({d, c, b, a});
    send(d, 1'b1); load_cycles += send_cycles;
  endtask

  task automatic do_swap();
    int n;
    n = 0;
    swap_req = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!swap_ack && n < 20);
    if (!swap_ack) chk("swap_timeout", 0, 1);
    swap_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; swap_req = 1'b0;
    #2;
    chk("rst_bias_out", bias_out, 0);
    chk("rst_bias_valid", bias_valid, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_err_len", err_len, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // basic load + swap
    a0 = ack_cnt;
    load4(32'd1, 32'd2, 32'd3, 32'd4);
    do_swap();
    @(negedge clk); #1;
    chk("t1_acks", ack_cnt - a0, 1);
    chk("t1_vec", bias_out, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("t1_valid", bias_valid, 1);

    // swap_req held throughout the fill
    swap_req = 1'b1;
    load4(-32'sd5, 32'd0, 32'd7, -32'sd1);
    chk("t2_cycles", load_cycles, 4);
    chk("t2_full_rdy", in_ready, 0);
    chk("t2_no_early_ack", swap_ack, 0);
    @(posedge clk); #1;
    chk("t2_ack", swap_ack, 1);
    chk("t2_rdy_back", in_ready, 1);
    swap_req = 1'b0;
    @(negedge clk); #1;
    chk("t2_vec", bias_out, {32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFFB});

    // short vector
    e0 = err_cnt;
    hold_b = bias_out;
    send(32'd9, 1'b0);
    send(32'd9, 1'b1);
    @(negedge clk); #1;
    chk("t3_err", err_cnt - e0, 1);
    chk("t3_hold", bias_out, hold_b);
    load4(32'd10, 32'd20, 32'd30, 32'd40);
    do_swap();

    // missing last
    e0 = err_cnt;
    send(32'd11, 1'b0); send(32'd12, 1'b0); send(32'd13, 1'b0); send(32'd14, 1'b0);
    @(negedge clk); #1;
    chk("t4_err", err_cnt - e0, 1);
    a0 = ack_cnt;
    swap_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    swap_req = 1'b0;
    chk("t4_no_ack", ack_cnt - a0, 0);

    // stall in FULL with in_valid high
    load4(32'd100, 32'd200, 32'd300, 32'd400);
    in_valid = 1'b1; in_data = 32'd55; in_last = 1'b0;
    repeat (10) begin
      chk("t5_stall_rdy", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_swap();
    load4(32'd5, 32'd6, 32'd7, 32'd8);
    do_swap();

    // reset during beat 3 of the second vector
    load4(32'd21, 32'd22, 32'd23, 32'd24);
    do_swap();
    send(32'd31, 1'b0);
    send(32'd32, 1'b0);
    in_valid = 1'b1; in_data = 32'd33;
    #2 rst = 1'b1;
    #1;
    chk("t6_bias_out", bias_out, 0);
    chk("t6_bias_valid", bias_valid, 0);
    chk("t6_swap_ack", swap_ack, 0);
    chk("t6_err_len", err_len, 0);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rdy", in_ready, 1);
    load4(32'd41, 32'd42, 32'd43, 32'd44);
    do_swap();
    @(negedge clk); #1;
    chk("t6_vec", bias_out, {32'd44, 32'd43, 32'd42, 32'd41});

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
